alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 ALU_OP  input  3  operation select.
REQ-005 AB_SW  input  3  selects one of eight built-in operand pairs (A, B).
REQ-006 F  output  32  registered result.
REQ-007 OF  output  1  registered signed-overflow flag.
REQ-008 ZF  output  1  registered zero flag.

Function
REQ-009 The operand table SHALL be, as AB_SW -> A, B (hex):
- 000 -> 00000000, 00000000
- 001 -> 00000003, 00000607
- 010 -> 80000000, 80000000
- 011 -> 7FFFFFFF, 7FFFFFFF
- 100 -> 80000000, FFFFFFFF
- 101 -> FFFFFFFF, 80000000
- 110 -> FFFFFFFF, FFFFFFFF
- 111 -> 12345678, 33332222
REQ-010 ALU_OP decode SHALL be:
- 000 AND
- 001 OR
- 010 XOR
- 011 NOR
- 100 ADD (A+B, mod 2^32)
- 101 SUB (A-B, mod 2^32)
- 110 SLT: F = 1 if A < B as signed two's complement, else 0
- 111 SLL: F = B << A[4:0], zero fill
REQ-011 OF SHALL be 1 only for:
- ADD when A and B have equal sign bits and the result sign differs from them.
- SUB when A and B have different sign bits and the result sign differs from A.
OF SHALL be 0 for all other operations.
REQ-012 ZF SHALL be 1 exactly when the 32-bit result written to F is all zeros, for every operation.
REQ-013 Operand selection and the operation SHALL be combinational from ALU_OP and AB_SW.
- F, OF and ZF SHALL be registered together on each rising clk edge.
- Latency SHALL be one cycle, with no enable and no handshake.
- A new operation SHALL be accepted every cycle.
REQ-014 Input changes between edges SHALL NOT affect the outputs until the next rising edge.
REQ-015 SLT SHALL use a true signed comparison (correct even when A-B overflows), not the raw subtract sign bit.
REQ-016 SLL SHALL ignore A[31:5]; a shift of 0 SHALL return B unchanged.
REQ-017 Outputs SHALL never be X/Z after reset, for any of the 64 input combinations.

Reset
REQ-018 While rst=1, the outputs SHALL be F=00000000, OF=0, ZF=1, asynchronously and independent of clk.
REQ-019 Asserting rst mid-operation SHALL immediately force the reset values; the in-flight result SHALL be discarded.
REQ-020 On the first rising clk edge after rst deasserts, the outputs SHALL reflect the current ALU_OP and AB_SW.

Verification
REQ-021 Assert rst with ALU_OP=100, AB_SW=011 -> F=00000000, OF=0, ZF=1 before any clock edge.
REQ-022 After reset, apply ALU_OP=100, AB_SW=011, one clock -> F=FFFFFFFE, OF=1, ZF=0.
REQ-023 Apply each input pair and clock once:
- ALU_OP=101, AB_SW=010 -> F=00000000, ZF=1, OF=0.
- ALU_OP=101, AB_SW=101 -> F=7FFFFFFF, OF=0.
REQ-024 Apply each input pair and clock once:
- ALU_OP=001, AB_SW=001 -> F=00000607, ZF=0.
- ALU_OP=111, AB_SW=001 -> F=00003038.
REQ-025 Apply each input pair and clock once:
- ALU_OP=110, AB_SW=100 -> F=00000001.
- ALU_OP=110, AB_SW=101 -> F=00000000, ZF=1.
REQ-026 Apply ALU_OP=100, AB_SW=100, and change the inputs between edges -> the outputs hold until the next rising edge, then show F=7FFFFFFF, OF=1; assert rst mid-cycle -> the outputs clear at once.

Source files
------------

// File: rtl/alu.sv
// 32-bit ALU with a built-in operand table; result and flags are registered
// together, giving one-cycle latency and a new operation every clock.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ALU_OP,
  input  logic [2:0]  AB_SW,
  output logic [31:0] F,
  output logic        OF,
  output logic        ZF
);

  logic [31:0] a, b;
  logic [31:0] sum, diff;
  logic [31:0] f_d, f_q;
  logic        of_d, of_q;
  logic        zf_d, zf_q;

  always_comb begin
    a = 32'h0000_0000;
    b = 32'h0000_0000;
    case (AB_SW)
      3'b000: begin a = 32'h0000_0000; b = 32'h0000_0000; end
      3'b001: begin a = 32'h0000_0003; b = 32'h0000_0607; end
      3'b010: begin a = 32'h8000_0000; b = 32'h8000_0000; end
      3'b011: begin a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; end
      3'b100: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      3'b101: begin a = 32'hFFFF_FFFF; b = 32'h8000_0000; end
      3'b110: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
      default: begin a = 32'h1234_5678; b = 32'h3333_2222; end
    endcase
  end

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    f_d  = 32'h0000_0000;
    of_d = 1'b0;
    case (ALU_OP)
      3'b000: f_d = a & b;
      3'b001: f_d = a | b;
      3'b010: f_d = a ^ b;
      3'b011: f_d = ~(a | b);
      3'b100: begin
        f_d  = sum;
        of_d = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      3'b101: begin
        f_d  = diff;
        of_d = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      // Signed compare rather than diff[31], so overflowing subtracts stay correct.
      3'b110: f_d = {31'd0, ($signed(a) < $signed(b))};
      default: f_d = b << a[4:0];
    endcase
    zf_d = (f_d == 32'h0000_0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q  <= 32'h0000_0000;
      of_q <= 1'b0;
      zf_q <= 1'b1;
    end else begin
      f_q  <= f_d;
      of_q <= of_d;
      zf_q <= zf_d;
    end
  end

  assign F  = f_q;
  assign OF = of_q;
  assign ZF = zf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, hold/reset timing, an
// exhaustive sweep of all 64 input pairs and randomized traffic against a model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [2:0]  ALU_OP;
  logic [2:0]  AB_SW;
  logic [31:0] F;
  logic        OF;
  logic        ZF;

  int n_cmp;
  int n_bad;

  logic [31:0] tab_a [8];
  logic [31:0] tab_b [8];

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .ALU_OP (ALU_OP),
    .AB_SW  (AB_SW),
    .F      (F),
    .OF     (OF),
    .ZF     (ZF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operand table.
  function automatic void model(input logic [2:0] op, input logic [2:0] sw,
                                output logic [31:0] f, output logic of);
    logic [31:0] a, b;
    longint sa, sb, r;
    a  = tab_a[sw];
    b  = tab_b[sw];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    of = 1'b0;
    f  = 32'h0;
    case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = a ^ b;
      3'd3: f = ~(a | b);
      3'd4: begin
        r  = sa + sb;
        f  = 32'(r);
        of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd5: begin
        r  = sa - sb;
        f  = 32'(r);
        of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd6: f = (sa < sb) ? 32'd1 : 32'd0;
      default: f = 32'(longint'(b) * (longint'(1) << (a % 32)));
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] f_exp,
                       input logic of_exp, input logic zf_exp);
    n_cmp++;
    assert (F === f_exp) else begin
      n_bad++;
      $error("FAIL %s F observed=%h expected=%h", tag, F, f_exp);
    end
    n_cmp++;
    assert (OF === of_exp) else begin
      n_bad++;
      $error("FAIL %s OF observed=%b expected=%b", tag, OF, of_exp);
    end
    n_cmp++;
    assert (ZF === zf_exp) else begin
      n_bad++;
      $error("FAIL %s ZF observed=%b expected=%b", tag, ZF, zf_exp);
    end
    $display("[%0t] %s op=%b sw=%b F=%h OF=%b ZF=%b", $time, tag, ALU_OP, AB_SW, F, OF, ZF);
  endtask

  // Apply inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input string tag, input logic [2:0] op, input logic [2:0] sw);
    logic [31:0] fe;
    logic        oe;
    @(negedge clk);
    ALU_OP = op;
    AB_SW  = sw;
    @(posedge clk);
    #1;
    model(op, sw, fe, oe);
    check(tag, fe, oe, (fe == 32'h0));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tab_a[0] = 32'h00000000; tab_b[0] = 32'h00000000;
    tab_a[1] = 32'h00000003; tab_b[1] = 32'h00000607;
    tab_a[2] = 32'h80000000; tab_b[2] = 32'h80000000;
    tab_a[3] = 32'h7FFFFFFF; tab_b[3] = 32'h7FFFFFFF;
    tab_a[4] = 32'h80000000; tab_b[4] = 32'hFFFFFFFF;
    tab_a[5] = 32'hFFFFFFFF; tab_b[5] = 32'h80000000;
    tab_a[6] = 32'hFFFFFFFF; tab_b[6] = 32'hFFFFFFFF;
    tab_a[7] = 32'h12345678; tab_b[7] = 32'h33332222;

    // Reset before any clock edge.
    ALU_OP = 3'b100;
    AB_SW  = 3'b011;
    rst    = 1'b1;
    #2;
    check("reset_pre_clk", 32'h0, 1'b0, 1'b1);

    // First edge after release reflects the current inputs.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("add_ovf_first", 32'hFFFFFFFE, 1'b1, 1'b0);

    // Directed vectors with hand-derived expectations.
    @(negedge clk); ALU_OP = 3'b101; AB_SW = 3'b010; @(posedge clk); #1;
    check("sub_zero", 32'h00000000, 1'b0, 1'b1);
    @(negedge clk); ALU_OP = 3'b101; AB_SW = 3'b101; @(posedge clk); #1;
    check("sub_no_ovf", 32'h7FFFFFFF, 1'b0, 1'b0);
    @(negedge clk); ALU_OP = 3'b001; AB_SW = 3'b001; @(posedge clk); #1;
    check("or", 32'h00000607, 1'b0, 1'b0);
    @(negedge clk); ALU_OP = 3'b111; AB_SW = 3'b001; @(posedge clk); #1;
    check("sll", 32'h00003038, 1'b0, 1'b0);
    @(negedge clk); ALU_OP = 3'b110; AB_SW = 3'b100; @(posedge clk); #1;
    check("slt_true", 32'h00000001, 1'b0, 1'b0);
    @(negedge clk); ALU_OP = 3'b110; AB_SW = 3'b101; @(posedge clk); #1;
    check("slt_false", 32'h00000000, 1'b0, 1'b1);
    @(negedge clk); ALU_OP = 3'b111; AB_SW = 3'b000; @(posedge clk); #1;
    check("sll_zero", 32'h00000000, 1'b0, 1'b1);
    @(negedge clk); ALU_OP = 3'b111; AB_SW = 3'b110; @(posedge clk); #1;
    check("sll_31", 32'h80000000, 1'b0, 1'b0);
    @(negedge clk); ALU_OP = 3'b110; AB_SW = 3'b010; @(posedge clk); #1;
    check("slt_equal", 32'h00000000, 1'b0, 1'b1);
    @(negedge clk); ALU_OP = 3'b011; AB_SW = 3'b000; @(posedge clk); #1;
    check("nor", 32'hFFFFFFFF, 1'b0, 1'b0);

    // Inputs changing between edges must not reach the outputs early.
    @(negedge clk); ALU_OP = 3'b100; AB_SW = 3'b100;
    #1;
    check("hold_before_edge", 32'hFFFFFFFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("add_neg_ovf", 32'h7FFFFFFF, 1'b1, 1'b0);
    #1; ALU_OP = 3'b000; AB_SW = 3'b000;
    #1;
    check("hold_after_change", 32'h7FFFFFFF, 1'b1, 1'b0);
    #1; rst = 1'b1;
    #1;
    check("reset_mid_cycle", 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("reset_held_edge", 32'h0, 1'b0, 1'b1);
    @(negedge clk); rst = 1'b0; ALU_OP = 3'b010; AB_SW = 3'b111;
    @(posedge clk); #1;
    check("xor_after_reset", 32'h2107745A, 1'b0, 1'b0);

    // Every operation against every operand pair.
    for (int op = 0; op < 8; op++) begin
      for (int sw = 0; sw < 8; sw++) begin
        step("sweep", 3'(op), 3'(sw));
      end
    end

    // Randomized back-to-back traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
